// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the PWM audio DAC driver
package dac_pkg;
  localparam int DAC_SAMPLE_W = 8;
  localparam int FULL_GAIN = 2**DAC_SAMPLE_W;
  typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} dac_state_t;
endpackage

// File: rtl/dac_pwm_driver_pwm_core.sv
// pwm_core: free-running frame counter, frame pulse and duty compare for a registered PWM pin
module pwm_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] duty_i,
  output logic         boundary_o,
  output logic         pwm_o,
  output logic         frame_o
);
  logic [W-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic pwm_q, pwm_d, frame_q, frame_d;
  // Outputs are registered, so they are computed from the next-cycle counter and duty
  always_comb begin
    cnt_d = cnt_q + W'(1);
    duty_d = load_i ? duty_i : duty_q;
    pwm_d = cnt_d < duty_d;
    frame_d = cnt_d == '0;
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      duty_q <= '0;
      pwm_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      duty_q <= duty_d;
      pwm_q <= pwm_d;
      frame_q <= frame_d;
    end
  end
  assign boundary_o = &cnt_q;
  assign pwm_o = pwm_q;
  assign frame_o = frame_q;
endmodule

// File: rtl/dac_pwm_driver.sv
// dac_pwm_driver: soft-mute gain FSM and sample scaling feeding a single-pin PWM output
module dac_pwm_driver
  import dac_pkg::*;
#(
  parameter int SAMPLE_W = DAC_SAMPLE_W,
  parameter int RAMP_STEP = 4
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] dacCount_i,
  output logic                pwm_o,
  output logic                frame_o,
  output logic                active_o
);
  localparam int GW = SAMPLE_W + 1;
  localparam int PW = 2 * SAMPLE_W + 1;
  localparam logic [GW-1:0] FULL = GW'(2**SAMPLE_W);
  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);
  dac_state_t state_q, state_d, st_n;
  logic [GW-1:0] gain_q, gain_d, gain_n, gain_up, gain_dn;
  logic [GW:0] up_sum;
  logic [SAMPLE_W-1:0] duty;
  logic active_q, active_d, boundary;
  // en_i redirects the ramp at once; the gain itself only moves on frame boundaries
  always_comb begin
    st_n = en_i ? ((state_q == MUTED || state_q == RAMP_DOWN) ? RAMP_UP : state_q)
                : ((state_q == RAMP_UP || state_q == PLAY) ? RAMP_DOWN : state_q);
    up_sum = {1'b0, gain_q} + {1'b0, STEP};
    gain_up = (up_sum >= {1'b0, FULL}) ? FULL : up_sum[GW-1:0];
    gain_dn = (gain_q > STEP) ? gain_q - STEP : '0;
    gain_n = st_n == RAMP_UP ? gain_up : st_n == RAMP_DOWN ? gain_dn : st_n == PLAY ? FULL : '0;
    gain_d = boundary ? gain_n : gain_q;
    state_d = !boundary ? st_n
            : (st_n == RAMP_UP && gain_n == FULL) ? PLAY
            : (st_n == RAMP_DOWN && gain_n == '0) ? MUTED : st_n;
    active_d = state_d != MUTED;
    duty = SAMPLE_W'((PW'(dacCount_i) * PW'(gain_n)) >> SAMPLE_W);
  end
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MUTED;
      gain_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q <= gain_d;
      active_q <= active_d;
    end
  end
  pwm_core #(.W(SAMPLE_W)) u_pwm (
    .clk       (clk),
    .rst_i     (rst_i),
    .load_i    (boundary),
    .duty_i    (duty),
    .boundary_o(boundary),
    .pwm_o     (pwm_o),
    .frame_o   (frame_o)
  );
  assign active_o = active_q;
endmodule

// File: tb/tb_dac_pwm_driver.sv
// tb_dac_pwm_driver: directed frame-level checks of duty, gain ramps, frame pulse and reset
module tb_dac_pwm_driver;
  logic clk = 1'b0, rst_i = 1'b1, en_i = 1'b0;
  logic [7:0] dacCount_i = 8'd200;
  logic pwm_o, frame_o, active_o;
  int checks = 0, errors = 0;

  dac_pwm_driver #(.SAMPLE_W(8), .RAMP_STEP(64)) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .dacCount_i(dacCount_i),
    .pwm_o     (pwm_o),
    .frame_o   (frame_o),
    .active_o  (active_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // From a negedge, count negedges until frame_o is seen high
  task automatic frame_gap(input string tag, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 600);
    check(tag, n, exp);
  endtask

  // Called at the negedge where cnt==0; counts high cycles over one full frame,
  // optionally changing sample/enable when cnt==at
  task automatic frame(input string tag, input int at, input logic [7:0] d, input logic e, input int exp);
    int h = 0;
    check({tag, "_align"}, frame_o, 1);
    for (int i = 0; i < 256; i++) begin
      if (i == at) begin
        dacCount_i = d;
        en_i = e;
      end
      h += int'(pwm_o);
      @(negedge clk);
    end
    check(tag, h, exp);
  endtask

  initial begin
    #3;
    check("rst_pwm", pwm_o, 0);
    check("rst_frame", frame_o, 0);
    check("rst_active", active_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    frame_gap("first_frame", 256);
    frame("muted", -1, 8'd200, 1'b0, 0);
    check("muted_active", active_o, 0);
    // ramp up from MUTED with step 64
    frame("up_start", 2, 8'd200, 1'b1, 0);
    check("up_active", active_o, 1);
    frame("up_64", -1, 0, 0, 50);
    frame("up_128", -1, 0, 0, 100);
    frame("up_192", -1, 0, 0, 150);
    frame("up_256", -1, 0, 0, 200);
    frame("play_200", -1, 0, 0, 200);
    // mid-frame sample changes apply from the next frame
    frame("play_still200", 5, 8'd128, 1'b1, 200);
    frame("play_128", 40, 8'd10, 1'b1, 128);
    frame("play_10", -1, 0, 0, 10);
    frame("play_10b", 40, 8'd0, 1'b1, 10);
    frame("play_0", -1, 0, 0, 0);
    frame("play_0b", 40, 8'd255, 1'b1, 0);
    frame("play_255", -1, 0, 0, 255);
    // ramp down from PLAY to MUTED
    frame("dn_start", 40, 8'd200, 1'b0, 255);
    frame("dn_192", -1, 0, 0, 150);
    frame("dn_128", -1, 0, 0, 100);
    frame("dn_64", -1, 0, 0, 50);
    check("dn_active", active_o, 0);
    frame("dn_muted", -1, 0, 0, 0);
    // ramp up, drop at gain 128, re-raise in RAMP_DOWN
    frame("re_start", 40, 8'd200, 1'b1, 0);
    frame("re_64", -1, 0, 0, 50);
    frame("re_128_drop", 40, 8'd200, 1'b0, 100);
    frame("re_64_raise", 40, 8'd200, 1'b1, 50);
    check("re_active", active_o, 1);
    frame("re_128", -1, 0, 0, 100);
    frame("re_192", -1, 0, 0, 150);
    frame("re_256", -1, 0, 0, 200);
    frame("re_play", -1, 0, 0, 200);
    for (int f = 0; f < 10; f++) frame_gap($sformatf("gap%0d", f), 256);
    // async reset mid-PLAY, off the clock edge, at cnt==0
    check("pre_rst_frame", frame_o, 1);
    check("pre_rst_pwm", pwm_o, 1);
    check("pre_rst_active", active_o, 1);
    #2 rst_i = 1'b1;
    en_i = 1'b0;
    #1;
    check("arst_pwm", pwm_o, 0);
    check("arst_frame", frame_o, 0);
    check("arst_active", active_o, 0);
    repeat (3) @(negedge clk);
    check("hold_frame", frame_o, 0);
    rst_i = 1'b0;
    frame_gap("post_rst_frame", 256);
    frame("post_rst_muted", -1, 0, 0, 0);
    check("post_rst_active", active_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
